// File: rtl/axis_pkt_fifo.sv
`default_nettype none
// ============================================================================
// Module      : axis_pkt_fifo
// Description : Synchronous AXI4-Stream FIFO, optional store-and-forward mode
//               with oversize-packet discard.
// Revision    : 1.0 - initial release
// ============================================================================
module axis_pkt_fifo #(
    parameter int DEPTH         = 32,
    parameter int DATA_W        = 8,
    parameter int ID_W          = 1,
    parameter int DEST_W        = 1,
    parameter int USER_W        = 1,
    parameter int PACKET_MODE   = 0,
    parameter int DROP_OVERSIZE = 1,
    parameter int AF_LEVEL      = DEPTH - 4
) (
    input  logic                    axis_clk,
    input  logic                    axis_rst_n,

    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    input  logic [DATA_W-1:0]       s_axis_tdata,
    input  logic [DATA_W/8-1:0]     s_axis_tstrb,
    input  logic [DATA_W/8-1:0]     s_axis_tkeep,
    input  logic                    s_axis_tlast,
    input  logic [ID_W-1:0]         s_axis_tid,
    input  logic [DEST_W-1:0]       s_axis_tdest,
    input  logic [USER_W-1:0]       s_axis_tuser,

    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic [DATA_W-1:0]       m_axis_tdata,
    output logic [DATA_W/8-1:0]     m_axis_tstrb,
    output logic [DATA_W/8-1:0]     m_axis_tkeep,
    output logic                    m_axis_tlast,
    output logic [ID_W-1:0]         m_axis_tid,
    output logic [DEST_W-1:0]       m_axis_tdest,
    output logic [USER_W-1:0]       m_axis_tuser,

    output logic [$clog2(DEPTH):0]  status_count,
    output logic                    status_almost_full,
    output logic                    status_drop
);

    localparam int c_aw    = $clog2(DEPTH);
    localparam int c_ptr_w = c_aw + 1;
    localparam int c_bw    = DATA_W / 8;
    localparam int c_ent_w = DATA_W + 2 * c_bw + 1 + ID_W + DEST_W + USER_W;

    localparam logic [c_ptr_w-1:0] c_depth  = c_ptr_w'(DEPTH);
    localparam logic [c_ptr_w-1:0] c_af     = c_ptr_w'(AF_LEVEL);
    localparam bit                 c_pkt    = (PACKET_MODE != 0);
    localparam bit                 c_drop_en = c_pkt && (DROP_OVERSIZE != 0);

    typedef enum logic [0:0] {
        ST_ACCEPT = 1'b0,
        ST_DROP   = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [c_ptr_w-1:0]   wr_ptr_q, wr_ptr_d;
    logic [c_ptr_w-1:0]   commit_ptr_q, commit_ptr_d;
    logic [c_ptr_w-1:0]   rd_ptr_q, rd_ptr_d;
    logic                 rdy_en_q;
    logic                 drop_q, drop_d;
    logic                 mem_we;

    logic [c_ent_w-1:0]   mem_q [DEPTH];

    logic [c_ptr_w-1:0]   w_used;
    logic [c_ptr_w-1:0]   w_wr_inc;
    logic [c_ptr_w-1:0]   w_pkt_len;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_wr_fire;
    logic                 w_rd_fire;
    logic [c_ent_w-1:0]   w_wr_entry;
    logic [c_ent_w-1:0]   w_rd_entry;

    assign w_used    = wr_ptr_q - rd_ptr_q;
    assign w_wr_inc  = wr_ptr_q + 1'b1;
    assign w_pkt_len = w_wr_inc - commit_ptr_q;
    assign w_full    = (w_used == c_depth);
    assign w_empty   = (commit_ptr_q == rd_ptr_q);

    // Ready is decoded from registered state only; tvalid never feeds back.
    assign s_axis_tready = rdy_en_q && ((state_q == ST_DROP) || !w_full);
    assign m_axis_tvalid = !w_empty;

    assign w_wr_fire = s_axis_tvalid && s_axis_tready;
    assign w_rd_fire = m_axis_tvalid && m_axis_tready;

    assign w_wr_entry = {s_axis_tdata, s_axis_tstrb, s_axis_tkeep, s_axis_tlast,
                         s_axis_tid, s_axis_tdest, s_axis_tuser};
    assign w_rd_entry = mem_q[rd_ptr_q[c_aw-1:0]];
    assign {m_axis_tdata, m_axis_tstrb, m_axis_tkeep, m_axis_tlast,
            m_axis_tid, m_axis_tdest, m_axis_tuser} = w_rd_entry;

    assign status_count       = w_used;
    assign status_almost_full = (w_used >= c_af);
    assign status_drop        = drop_q;

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        commit_ptr_d = commit_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        drop_d       = 1'b0;
        mem_we       = 1'b0;

        if (w_rd_fire) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        case (state_q)
            ST_ACCEPT: begin
                if (w_wr_fire) begin
                    mem_we   = 1'b1;
                    wr_ptr_d = w_wr_inc;
                    if (c_pkt && s_axis_tlast) begin
                        commit_ptr_d = w_wr_inc;
                    end else if (c_drop_en && (w_pkt_len == c_depth)) begin
                        // Packet cannot fit: rewind to the last commit and discard the rest.
                        mem_we   = 1'b0;
                        wr_ptr_d = commit_ptr_q;
                        state_d  = ST_DROP;
                    end
                end
            end
            ST_DROP: begin
                if (w_wr_fire && s_axis_tlast) begin
                    state_d = ST_ACCEPT;
                    drop_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_ACCEPT;
            end
        endcase

        if (!c_pkt) begin
            commit_ptr_d = wr_ptr_d;
        end
    end

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            state_q      <= ST_ACCEPT;
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
            rd_ptr_q     <= '0;
            rdy_en_q     <= 1'b0;
            drop_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            rdy_en_q     <= 1'b1;
            drop_q       <= drop_d;
        end
    end

    // Storage is intentionally not reset.
    always_ff @(posedge axis_clk) begin
        if (mem_we) begin
            mem_q[wr_ptr_q[c_aw-1:0]] <= w_wr_entry;
        end
    end

endmodule
`default_nettype wire
